// File: rtl/onchip_arb_pkg.sv
// onchip_arb_pkg: shared defaults and read-tag type for the on-chip memory arbiter
package onchip_arb_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;
endpackage

// File: rtl/onchip_arb_rr.sv
// onchip_arb_rr: two-way grant selection, round-robin with burst hold; fixed priority under ONCHIP_ARB_FIXED_PRI_EN
module onchip_arb_rr #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] active,
  output logic [1:0] grant
);
`ifdef ONCHIP_ARB_FIXED_PRI_EN
  assign grant = active[0] ? 2'b01 : {active[1], 1'b0};
`else
  localparam int CW = $clog2(MAX_BURST + 1) < 2 ? 2 : $clog2(MAX_BURST + 1);
  logic          last;
  logic          win;
  logic [CW-1:0] cnt;
  // cnt == 0 means no burst in progress, so the not-last requester wins
  always_comb begin
    win   = active[1] && (!active[0] || ((cnt != '0 && cnt < CW'(MAX_BURST)) ? last : !last));
    grant = (|active) ? (win ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
      cnt  <= '0;
    end else if (|active) begin
      last <= win;
      cnt  <= (win != last) ? CW'(1) : (cnt < CW'(MAX_BURST) ? cnt + 1'b1 : cnt);
    end
  end
`endif
endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port RAM between two requesters.
// Define ONCHIP_ARB_FIXED_PRI_EN for fixed priority to requester 0.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic [1:0] active;
  logic [1:0] grant;
  rd_tag_t    tag;
  // nothing is accepted until the RAM clock is enabled, which also blocks grants during reset
  assign active = {m1_read | m1_write, m0_read | m0_write} & {2{mem_clken}};
  onchip_arb_rr #(.MAX_BURST(MAX_BURST)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .active (active),
    .grant  (grant)
  );
  always_comb begin
    mem_address      = grant[1] ? m1_address : m0_address;
    mem_byteenable   = grant[1] ? m1_byteenable : m0_byteenable;
    mem_writedata    = grant[1] ? m1_writedata : m0_writedata;
    mem_write        = grant[1] ? m1_write : grant[0] & m0_write;
    mem_chipselect   = |grant;
    m0_waitrequest   = ~grant[0];
    m1_waitrequest   = ~grant[1];
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdatavalid = tag.valid & ~tag.id;
    m1_readdatavalid = tag.valid & tag.id;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag       <= '0;
      mem_clken <= 1'b0;
    end else begin
      mem_clken <= 1'b1;
      tag       <= '{valid: mem_chipselect & ~mem_write, id: grant[1]};
    end
  end
endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: ports clk and reset.
REQ-002 Parameter ADDR_W, default 10, SHALL set the word-address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the data width; the byteenable width SHALL be DATA_W/8.
REQ-004 Parameter MAX_BURST, default 4, SHALL set the maximum number of consecutive accepted transfers granted to one requester while the other is requesting.
REQ-005 Ports SHALL be:
 clk  in  1  clock
 reset  in  1  asynchronous active-high reset
 mN_address  in  ADDR_W  requester N (N=0,1) word address
 mN_byteenable  in  DATA_W/8  requester N byte lanes
 mN_read  in  1  requester N read request
 mN_write  in  1  requester N write request
 mN_writedata  in  DATA_W  requester N write data
 mN_waitrequest  out  1  request not accepted this cycle
 mN_readdata  out  DATA_W  read return data
 mN_readdatavalid  out  1  mN_readdata valid
 mem_address  out  ADDR_W  to single-port RAM
 mem_byteenable  out  DATA_W/8  to RAM
 mem_chipselect  out  1  to RAM
 mem_write  out  1  to RAM
 mem_writedata  out  DATA_W  to RAM
 mem_clken  out  1  RAM clock enable
 mem_readdata  in  DATA_W  RAM output, valid one cycle after address is sampled

Function
REQ-006 A requester SHALL be active when mN_read or mN_write is high; if both are high, the request SHALL be treated as a write.
REQ-007 Each cycle, at most one active requester SHALL be granted; the winner's address, byteenable, writedata and write SHALL drive the mem_* outputs combinationally, with mem_chipselect=1.
REQ-008 The winner's waitrequest SHALL be 0 in the grant cycle; the loser's, and that of every inactive requester, SHALL be 1.
REQ-009 With no active requester, mem_chipselect and mem_write SHALL be 0.
REQ-010 Arbitration SHALL be round-robin: a 1-bit last-grant register; when both are active, the requester not last granted SHALL win, subject to REQ-011.
REQ-011 A 2-bit-or-wider burst counter SHALL let the last-granted requester keep the grant while it stays active, for up to MAX_BURST consecutive grants; the counter SHALL reset to 1 on a grant switch, and when it reaches MAX_BURST with the other requester active, the grant SHALL switch.
REQ-012 For an accepted read, a registered tag (valid and requester id) SHALL assert the readdatavalid of that requester exactly one cycle later, with mN_readdata = mem_readdata.
REQ-013 mN_readdata SHALL be driven from mem_readdata to both requesters; readdatavalid SHALL be high only for the tagged requester.
REQ-014 Back-to-back reads SHALL sustain one accepted read per cycle, with no bubble.
REQ-015 A write accepted in the cycle after a read SHALL NOT suppress that read's readdatavalid.

Reset
REQ-016 While reset is high: both waitrequests=1, readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0, last-grant=1 (requester 0 wins first), burst counter=0, read tag cleared.
REQ-017 mem_clken SHALL be a register set to 1 on the first clk edge after reset deasserts.
REQ-018 A reset asserted while a read is in flight SHALL discard that read; no readdatavalid SHALL be issued for it.

Configuration
REQ-019 With ONCHIP_ARB_FIXED_PRI_EN defined, requester 0 SHALL always win when active, and the round-robin and burst logic (REQ-010, REQ-011) SHALL be removed; without the macro, REQ-010 and REQ-011 apply.

Structure
REQ-020 A shared package onchip_arb_pkg SHALL hold the ADDR_W and DATA_W defaults and the read-tag struct (valid, id).
REQ-021 Grant selection SHALL sit in one sub-module, onchip_arb_rr (last-grant, burst counter, grant vector); the mux and read tag SHALL stay in the top level.

Verification
REQ-022 Scenario: reset, then m0 reads address 0x005 only. Required: m0_waitrequest=0 in the same cycle; m0_readdatavalid=1 the next cycle with the RAM word at 0x005.
REQ-023 Scenario: m0 and m1 both issue continuous writes, MAX_BURST=4. Required: grants 0,0,0,0,1,1,1,1,0...; no cycle with both waitrequests 0.
REQ-024 Scenario: m1 writes 0xDEADBEEF with byteenable 0x3 to 0x3FF, and is then read back by m0 with the RAM pre-cleared. Required: m0 reads 0x0000BEEF.
REQ-025 Scenario: m0 reads 0x010, then m1 writes in the next cycle. Required: m0_readdatavalid=1 once, m1_readdatavalid=0 throughout.
REQ-026 Scenario: reset asserted in the cycle after an accepted m1 read. Required: m1_readdatavalid stays 0 and mem_clken=0 until the first clk edge after reset releases.
REQ-027 Scenario: build with ONCHIP_ARB_FIXED_PRI_EN and run both requesters continuously. Required: m1_waitrequest remains 1 for 20 cycles.
